// File: rtl/hex_sr_pkg.sv
// Shared constants and state encoding for the hex_sr loop and its
// random-access port.
package hex_sr_pkg;

  localparam int HEX_SR_LENGTH = 40;
  localparam int HEX_SR_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } port_state_t;

endpackage

// File: rtl/hex_sr_port_if.sv
// Request/response handshake between a requester and hex_sr_port.
interface hex_sr_port_if #(
  parameter int AW    = 6,
  parameter int WIDTH = 6
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/hex_sr.sv
// Recirculating LENGTH x WIDTH shift register; shifts every clock and either
// loops sr_out back in (recirc=1) or loads sr_in. Contents are not reset.
module hex_sr
  import hex_sr_pkg::*;
#(
  parameter int LENGTH = HEX_SR_LENGTH,
  parameter int WIDTH  = HEX_SR_WIDTH
) (
  input  logic             clk,
  input  logic             recirc,
  input  logic [WIDTH-1:0] sr_in,
  output logic [WIDTH-1:0] sr_out
);

  logic [WIDTH-1:0] stage [LENGTH];

  // Shift chain with the recirculation mux at its head.
  always_ff @(posedge clk) begin
    stage[0] <= recirc ? stage[LENGTH-1] : sr_in;
    for (int i = 1; i < LENGTH; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign sr_out = stage[LENGTH-1];

endmodule

// File: rtl/hex_sr_pos_ctr.sv
// Modulo-LENGTH position counter tracking which logical word is on sr_out.
module hex_sr_pos_ctr
  import hex_sr_pkg::*;
#(
  parameter  int LENGTH = HEX_SR_LENGTH,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] pos
);

  localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  // Advance once per clock, wrapping after the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= {AW{1'b0}};
    end else if (pos == LAST) begin
      pos <= {AW{1'b0}};
    end else begin
      pos <= pos + ONE;
    end
  end

endmodule

// File: rtl/hex_sr_port.sv
// Random-access port for hex_sr: waits for the addressed word to rotate onto
// sr_out, then captures it and optionally overwrites it with a recirc break.
module hex_sr_port
  import hex_sr_pkg::*;
#(
  parameter  int LENGTH = HEX_SR_LENGTH,
  parameter  int WIDTH  = HEX_SR_WIDTH,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  hex_sr_port_if.slave     bus,
  input  logic [WIDTH-1:0] sr_out,
  output logic             recirc,
  output logic [WIDTH-1:0] sr_in,
  output logic [AW-1:0]    pos
);

  port_state_t      state_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic             addr_ok;
  logic             match;
  logic             write_hit;

  hex_sr_pos_ctr #(.LENGTH(LENGTH)) u_pos_ctr (
    .clk   (clk),
    .reset (reset),
    .pos   (pos)
  );

  assign addr_ok = (int'(bus.req_addr) < LENGTH);
  assign match   = (state_q == WAIT) && (pos == addr_q);

  // Reset masks the write so a match cycle under reset leaves the loop intact.
  assign write_hit = match && we_q && !reset;

  // Request FSM with address/data latches and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {WIDTH{1'b0}};
      rdata_q <= {WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (addr_ok) begin
              we_q    <= bus.req_we;
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
              err_q   <= 1'b0;
              state_q <= WAIT;
            end else begin
              rdata_q <= {WIDTH{1'b0}};
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (match) begin
            rdata_q <= sr_out;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign recirc = !write_hit;
  assign sr_in  = write_hit ? wdata_q : {WIDTH{1'b0}};

endmodule

// File: tb/tb_hex_sr_port.sv
// Directed self-checking bench for hex_sr_port driving a real hex_sr loop.
module tb_hex_sr_port;
  import hex_sr_pkg::*;

  localparam int LEN = 40;
  localparam int W   = 6;
  localparam int AW  = 6;

  logic          clk;
  logic          reset;
  logic          recirc;
  logic [W-1:0]  sr_in;
  logic [W-1:0]  sr_out;
  logic [AW-1:0] pos;

  int n_total;
  int n_pass;
  int rsp_seen;
  int overlap;

  hex_sr_port_if #(.AW(AW), .WIDTH(W)) bus ();

  hex_sr_port #(.LENGTH(LEN), .WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sr_out (sr_out),
    .recirc (recirc),
    .sr_in  (sr_in),
    .pos    (pos)
  );

  hex_sr #(.LENGTH(LEN), .WIDTH(W)) u_sr (
    .clk    (clk),
    .recirc (recirc),
    .sr_in  (sr_in),
    .sr_out (sr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request (optionally when pos==at_pos) and follow it to its response.
  task automatic do_op(input logic we, input int addr, input logic [W-1:0] wdata, input int at_pos,
                       output logic [W-1:0] rdata, output logic err, output int lat,
                       output int drops, output int dpos, output logic [W-1:0] ddin);
    int  guard;
    bit  got;
    guard = 0; got = 1'b0; lat = 0; drops = 0; dpos = -1; ddin = '0; rdata = '0; err = 1'b0;
    @(posedge clk); #1;
    while (!(bus.req_ready === 1'b1 && (at_pos < 0 || int'(pos) == at_pos)) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    n_total++;
    if (guard >= 200) $display("FAIL accept_timeout addr=%0d: ready/pos not reached, required ready=1 pos=%0d", addr, at_pos);
    else n_pass++;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = AW'(addr); bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int c = 1; c <= LEN + 5; c++) begin
      @(negedge clk);
      if (recirc !== 1'b1) begin drops++; dpos = int'(pos); ddin = sr_in; end
      if (bus.rsp_valid === 1'b1 && bus.req_ready === 1'b1) overlap++;
      if (bus.rsp_valid === 1'b1) begin
        rdata = bus.rsp_rdata; err = bus.rsp_err; lat = c; got = 1'b1; rsp_seen++;
        break;
      end
      @(posedge clk); #1;
    end
    n_total++;
    if (!got) $display("FAIL rsp_timeout addr=%0d: no rsp_valid, required one within %0d cycles", addr, LEN + 5);
    else n_pass++;
  endtask

  task automatic test_reset_wrap();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, recirc} !== 4'b0001 || bus.rsp_rdata !== 6'd0 || sr_in !== 6'd0 || pos !== 6'd0)
      $display("FAIL reset_vals: ready=%b vld=%b err=%b rd=%h recirc=%b sr_in=%h pos=%0d, required 0 0 0 00 1 00 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, recirc, sr_in, pos);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 85; i++) begin
      @(negedge clk);
      n_total++;
      if (int'(pos) !== i % LEN || recirc !== 1'b1 || sr_in !== 6'd0)
        $display("FAIL wrap[%0d]: pos=%0d recirc=%b sr_in=%h, required pos=%0d recirc=1 sr_in=00", i, pos, recirc, sr_in, i % LEN);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL ready_after_reset: %b, required 1", bus.req_ready);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] rd, dd;
    logic er;
    int lat, drops, dpos, seen0, bad;
    seen0 = rsp_seen; bad = 0;
    for (int k = 0; k < LEN; k++) begin
      do_op(1'b1, k, W'(k), -1, rd, er, lat, drops, dpos, dd);
      n_total++;
      if (er !== 1'b0 || drops != 1 || dpos != k || dd !== W'(k))
        $display("FAIL fill_wr[%0d]: err=%b drops=%0d at pos %0d din=%h, required err=0 one drop at pos %0d din=%h", k, er, drops, dpos, dd, k, W'(k));
      else n_pass++;
    end
    for (int k = 0; k < LEN; k++) begin
      do_op(1'b0, k, 6'h00, -1, rd, er, lat, drops, dpos, dd);
      n_total++;
      if (rd !== W'(k) || er !== 1'b0 || drops != 0)
        $display("FAIL fill_rd[%0d]: rdata=%h err=%b drops=%0d, required rdata=%h err=0 drops=0", k, rd, er, drops, W'(k));
      else n_pass++;
    end
    n_total++;
    if (rsp_seen - seen0 != 2 * LEN) $display("FAIL fill_rsp_count: %0d, required %0d", rsp_seen - seen0, 2 * LEN);
    else n_pass++;
    n_total++;
    if (overlap != 0) $display("FAIL rsp_ready_overlap: %0d, required 0", overlap);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [W-1:0] rd, dd;
    logic er;
    int lat, drops, dpos;
    do_op(1'b1, 5, 6'h2A, -1, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (rd !== 6'd5 || er !== 1'b0) $display("FAIL wr5_old: rdata=%h err=%b, required 05 0", rd, er);
    else n_pass++;
    do_op(1'b0, 5, 6'h00, -1, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (rd !== 6'h2A || er !== 1'b0) $display("FAIL rd5: rdata=%h err=%b, required 2a 0", rd, er);
    else n_pass++;
    for (int i = 0; i < 2 * LEN; i++) begin
      @(negedge clk);
      if (pos == 6'd5) begin
        n_total++;
        if (sr_out !== 6'h2A) $display("FAIL sr_out_at5: %h, required 2a", sr_out);
        else n_pass++;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_latency();
    logic [W-1:0] rd, dd;
    logic er;
    int lat, drops, dpos;
    do_op(1'b0, 7, 6'h00, 6, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (lat != 2 || rd !== 6'd7) $display("FAIL lat_min: lat=%0d rdata=%h, required 2 07", lat, rd);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL rsp_one_cycle: rsp_valid=%b, required 0", bus.rsp_valid);
    else n_pass++;
    do_op(1'b0, 7, 6'h00, 7, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (lat != LEN + 1 || rd !== 6'd7) $display("FAIL lat_max: lat=%0d rdata=%h, required %0d 07", lat, rd, LEN + 1);
    else n_pass++;
    do_op(1'b1, 10, 6'h33, 9, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (drops != 1 || dpos != 10 || dd !== 6'h33 || lat != 2 || rd !== 6'd10)
      $display("FAIL wr10: drops=%0d pos=%0d din=%h lat=%0d old=%h, required 1 10 33 2 0a", drops, dpos, dd, lat, rd);
    else n_pass++;
  endtask

  task automatic test_error();
    logic [W-1:0] rd, dd;
    logic [W-1:0] snap [LEN];
    logic er;
    int lat, drops, dpos, bad;
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk); snap[int'(pos)] = sr_out; @(posedge clk);
    end
    do_op(1'b0, 40, 6'h00, -1, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (er !== 1'b1 || rd !== 6'd0 || lat != 1 || drops != 0)
      $display("FAIL err40: err=%b rdata=%h lat=%0d drops=%0d, required 1 00 1 0", er, rd, lat, drops);
    else n_pass++;
    do_op(1'b1, 63, 6'h15, -1, rd, er, lat, drops, dpos, dd);
    n_total++;
    if (er !== 1'b1 || rd !== 6'd0 || lat != 1 || drops != 0)
      $display("FAIL err63: err=%b rdata=%h lat=%0d drops=%0d, required 1 00 1 0", er, rd, lat, drops);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      if (sr_out !== snap[int'(pos)] || recirc !== 1'b1) bad++;
      @(posedge clk);
    end
    n_total++;
    if (bad != 0) $display("FAIL err_loop_intact: %0d differing words, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rd, dd;
    logic er;
    int lat, drops, dpos, guard, n3f, n30;
    do_op(1'b1, 30, 6'h30, -1, rd, er, lat, drops, dpos, dd);
    guard = 0;
    @(posedge clk); #1;
    while (!(bus.req_ready === 1'b1 && pos == 6'd31) && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 6'd30; bus.req_wdata = 6'h3F;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.rsp_valid !== 1'b0 || recirc !== 1'b1 || bus.req_ready !== 1'b0)
      $display("FAIL mid_reset: vld=%b recirc=%b ready=%b, required 0 1 0", bus.rsp_valid, recirc, bus.req_ready);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (pos !== 6'd0 || bus.rsp_valid !== 1'b0 || recirc !== 1'b1 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 6'd0)
      $display("FAIL post_reset: pos=%0d vld=%b recirc=%b ready=%b rd=%h, required 0 0 1 1 00", pos, bus.rsp_valid, recirc, bus.req_ready, bus.rsp_rdata);
    else n_pass++;
    guard = 0;
    @(posedge clk); #1;
    while (!(bus.req_ready === 1'b1 && pos == 6'd19) && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 6'd20; bus.req_wdata = 6'h3F;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (recirc !== 1'b1 || sr_in !== 6'd0) $display("FAIL match_reset: recirc=%b sr_in=%h, required 1 00", recirc, sr_in);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    n3f = 0; n30 = 0;
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      if (sr_out === 6'h3F) n3f++;
      if (sr_out === 6'h30) n30++;
      @(posedge clk);
    end
    n_total++;
    if (n3f != 0 || n30 != 1) $display("FAIL discarded_write: words 3f=%0d 30=%0d, required 0 1", n3f, n30);
    else n_pass++;
  endtask

  initial begin
    n_total = 0; n_pass = 0; rsp_seen = 0; overlap = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset_wrap();
    test_fill();
    test_write_read();
    test_latency();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
